frv_gpr_writeback: RTL and testbench

//  Writeback stage directly upstream of the GPR file. Accepts results from two producers (s0: single-cycle
//  ALU path, s1: long-latency mul/div/load path), buffers them in a FIFO, and drives one registered write
//  per cycle onto the GPR write port (rd_wen/rd_wide/rd_addr/rd_wdata/rd_wdata_hi). Also provides a
//  per-register busy scoreboard for decode-stage stalls on rs1/rs2/rs3.

---
 rtl/frv_gpr_writeback.sv | 175 +++++++++++++++++
 tb/tb_frv_gpr_writeback.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/frv_gpr_writeback.sv
// GPR writeback stage: two producers into a result FIFO, one registered GPR write per cycle, rs busy scoreboard.
// Optional operand forwarding from pending results is enabled by defining FRV_WB_FWD_EN.
module frv_gpr_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     g_clk,
  input  logic                     g_reset,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic [4:0]               s0_rd_addr,
  input  logic                     s0_wide,
  input  logic [31:0]              s0_wdata,
  input  logic [31:0]              s0_wdata_hi,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  input  logic [4:0]               s1_rd_addr,
  input  logic                     s1_wide,
  input  logic [31:0]              s1_wdata,
  input  logic [31:0]              s1_wdata_hi,
  input  logic                     wb_hold,
  output logic                     rd_wen,
  output logic                     rd_wide,
  output logic [4:0]               rd_addr,
  output logic [31:0]              rd_wdata,
  output logic [31:0]              rd_wdata_hi,
  input  logic [4:0]               rs1_addr,
  input  logic [4:0]               rs2_addr,
  input  logic [4:0]               rs3_addr,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     rs3_busy,
  output logic                     rs1_fwd_valid,
  output logic                     rs2_fwd_valid,
  output logic                     rs3_fwd_valid,
  output logic [31:0]              rs1_fwd_data,
  output logic [31:0]              rs2_fwd_data,
  output logic [31:0]              rs3_fwd_data,
  output logic                     err_wide_odd,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        wide;
    logic [4:0]  addr;
    logic [31:0] lo;
    logic [31:0] hi;
  } wb_ent_t;

  wb_ent_t       mem [DEPTH];
  wb_ent_t       in_ent;
  wb_ent_t       out_ent;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          full, accepted, odd_wide, push, pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign s1_ready = !full;
  assign s0_ready = !full && !s1_valid;
  assign accepted = (s1_valid || s0_valid) && !full;

  // s1 has fixed priority, so whenever s1_valid is high the s0 payload is irrelevant
  assign in_ent = s1_valid ? '{wide: s1_wide, addr: s1_rd_addr, lo: s1_wdata, hi: s1_wdata_hi}
                           : '{wide: s0_wide, addr: s0_rd_addr, lo: s0_wdata, hi: s0_wdata_hi};

  assign odd_wide = accepted && in_ent.wide && in_ent.addr[0];
  assign push     = accepted && !odd_wide && !(in_ent.addr == 5'd0 && !in_ent.wide);
  assign pop      = (cnt != '0) && !wb_hold;
  assign occupancy = cnt;
  assign out_ent  = '{wide: rd_wide, addr: rd_addr, lo: rd_wdata, hi: rd_wdata_hi};

  always_ff @(posedge g_clk) begin
    if (push) mem[wptr] <= in_ent;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
      rd_wen       <= 1'b0;
      rd_wide      <= 1'b0;
      rd_addr      <= '0;
      rd_wdata     <= '0;
      rd_wdata_hi  <= '0;
      err_wide_odd <= 1'b0;
    end else begin
      err_wide_odd <= odd_wide;
      rd_wen       <= pop;
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr        <= rptr + 1'b1;
        rd_wide     <= mem[rptr].wide;
        rd_addr     <= mem[rptr].addr;
        rd_wdata    <= mem[rptr].lo;
        rd_wdata_hi <= mem[rptr].hi;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A wide entry at an even address claims the register pair {A, A|1}
  function automatic logic hit(input wb_ent_t e, input logic [4:0] a);
    return e.wide ? (e.addr[4:1] == a[4:1]) : (e.addr == a);
  endfunction

  logic [4:0]    rs_a [3];
  logic          busy_v [3];
  logic [AW-1:0] idx;

  assign rs_a[0] = rs1_addr;
  assign rs_a[1] = rs2_addr;
  assign rs_a[2] = rs3_addr;

`ifdef FRV_WB_FWD_EN
  function automatic logic [31:0] sel(input wb_ent_t e, input logic [4:0] a);
    return (e.wide && a[0]) ? e.hi : e.lo;
  endfunction

  logic [31:0] fwd_d [3];
`endif

  // Scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    idx = '0;
    for (int p = 0; p < 3; p++) begin
      busy_v[p] = 1'b0;
`ifdef FRV_WB_FWD_EN
      fwd_d[p] = '0;
`endif
      if (rd_wen && hit(out_ent, rs_a[p])) begin
        busy_v[p] = 1'b1;
`ifdef FRV_WB_FWD_EN
        fwd_d[p] = sel(out_ent, rs_a[p]);
`endif
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rptr + AW'(k);
        if (k < int'(cnt) && hit(mem[idx], rs_a[p])) begin
          busy_v[p] = 1'b1;
`ifdef FRV_WB_FWD_EN
          fwd_d[p] = sel(mem[idx], rs_a[p]);
`endif
        end
      end
      if (rs_a[p] == 5'd0) busy_v[p] = 1'b0;
    end
  end

  assign rs1_busy = busy_v[0];
  assign rs2_busy = busy_v[1];
  assign rs3_busy = busy_v[2];

`ifdef FRV_WB_FWD_EN
  assign rs1_fwd_valid = busy_v[0];
  assign rs2_fwd_valid = busy_v[1];
  assign rs3_fwd_valid = busy_v[2];
  assign rs1_fwd_data  = busy_v[0] ? fwd_d[0] : '0;
  assign rs2_fwd_data  = busy_v[1] ? fwd_d[1] : '0;
  assign rs3_fwd_data  = busy_v[2] ? fwd_d[2] : '0;
`else
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs3_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
  assign rs3_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_frv_gpr_writeback.sv
// Directed bench for frv_gpr_writeback: inputs change and outputs are checked on the falling clock edge.
module tb_frv_gpr_writeback;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        s0_valid = 0, s1_valid = 0, s0_wide = 0, s1_wide = 0, wb_hold = 0;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_rd_addr = 0, s1_rd_addr = 0;
  logic [31:0] s0_wdata = 0, s0_wdata_hi = 0, s1_wdata = 0, s1_wdata_hi = 0;
  logic        rd_wen, rd_wide;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata, rd_wdata_hi;
  logic [4:0]  rs1_addr = 0, rs2_addr = 0, rs3_addr = 0;
  logic        rs1_busy, rs2_busy, rs3_busy;
  logic        rs1_fwd_valid, rs2_fwd_valid, rs3_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data, rs3_fwd_data;
  logic        err_wide_odd;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FRV_WB_FWD_EN
  localparam logic        FWD_ON = 1'b1;
`else
  localparam logic        FWD_ON = 1'b0;
`endif

  frv_gpr_writeback #(.DEPTH(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd_addr(s0_rd_addr), .s0_wide(s0_wide),
    .s0_wdata(s0_wdata), .s0_wdata_hi(s0_wdata_hi),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd_addr(s1_rd_addr), .s1_wide(s1_wide),
    .s1_wdata(s1_wdata), .s1_wdata_hi(s1_wdata_hi),
    .wb_hold(wb_hold),
    .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .rd_wdata_hi(rd_wdata_hi),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs3_busy(rs3_busy),
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid), .rs3_fwd_valid(rs3_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data), .rs3_fwd_data(rs3_fwd_data),
    .err_wide_odd(err_wide_odd), .occupancy(occupancy)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge g_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    nxt(); nxt(); #1;
    chk("rst_wen", rd_wen, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_wdata", rd_wdata, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_err", err_wide_odd, 0);
    nxt(); g_reset = 0;

    // 1: single narrow result, latency and busy window
    nxt(); s0_valid = 1; s0_rd_addr = 5; s0_wdata = 32'hDEADBEEF; rs1_addr = 5; #1;
    chk("t1_s0_ready", s0_ready, 1);
    chk("t1_busy_pre", rs1_busy, 0);
    nxt(); s0_valid = 0; #1;
    chk("t1_occ", occupancy, 1);
    chk("t1_busy_q", rs1_busy, 1);
    chk("t1_wen_early", rd_wen, 0);
    nxt(); #1;
    chk("t1_wen", rd_wen, 1);
    chk("t1_addr", rd_addr, 5);
    chk("t1_wdata", rd_wdata, 64'hDEADBEEF);
    chk("t1_busy_out", rs1_busy, 1);
    chk("t1_occ0", occupancy, 0);
    nxt(); #1;
    chk("t1_wen_off", rd_wen, 0);
    chk("t1_busy_off", rs1_busy, 0);
    chk("t1_wdata_hold", rd_wdata, 64'hDEADBEEF);

    // 2: s1 priority over s0, writes in order
    nxt(); s0_valid = 1; s0_rd_addr = 10; s0_wdata = 32'hA;
    s1_valid = 1; s1_rd_addr = 11; s1_wdata = 32'hB; s1_wide = 0; #1;
    chk("t2_s0_ready", s0_ready, 0);
    chk("t2_s1_ready", s1_ready, 1);
    nxt(); s1_valid = 0; #1;
    chk("t2_s0_ready2", s0_ready, 1);
    chk("t2_occ", occupancy, 1);
    nxt(); s0_valid = 0; #1;
    chk("t2_w1_wen", rd_wen, 1);
    chk("t2_w1_addr", rd_addr, 11);
    chk("t2_w1_data", rd_wdata, 32'hB);
    nxt(); #1;
    chk("t2_w2_wen", rd_wen, 1);
    chk("t2_w2_addr", rd_addr, 10);
    chk("t2_w2_data", rd_wdata, 32'hA);
    nxt(); #1;
    chk("t2_idle", rd_wen, 0);

    // 3: hold fills the FIFO, then a full-rate drain
    wb_hold = 1;
    for (int i = 0; i < 5; i++) begin
      nxt(); s0_valid = 1; s0_rd_addr = 5'(i + 1); s0_wdata = 32'h100 + i + 1; #1;
      chk("t3_ready", s0_ready, (i < 4) ? 1 : 0);
      chk("t3_hold_wen", rd_wen, 0);
    end
    chk("t3_occ_full", occupancy, 4);
    chk("t3_s1_ready_full", s1_ready, 0);
    wb_hold = 0;
    for (int j = 0; j < 5; j++) begin
      nxt();
      if (j == 1) s0_valid = 0;
      #1;
      chk("t3_drain_wen", rd_wen, 1);
      chk("t3_drain_addr", rd_addr, j + 1);
      chk("t3_drain_data", rd_wdata, 32'h100 + j + 1);
      if (j == 0) begin
        chk("t3_occ_after1", occupancy, 3);
        chk("t3_5th_ready", s0_ready, 1);
      end
    end
    nxt(); #1;
    chk("t3_done_wen", rd_wen, 0);
    chk("t3_done_occ", occupancy, 0);

    // 4: wide write, odd-half busy/forward, odd-address discard
    nxt(); s1_valid = 1; s1_wide = 1; s1_rd_addr = 6; s1_wdata = 32'h1; s1_wdata_hi = 32'h2; rs2_addr = 7;
    nxt(); s1_valid = 0; #1;
    chk("t4_occ", occupancy, 1);
    chk("t4_busy_hi", rs2_busy, 1);
    chk("t4_fwd_valid", rs2_fwd_valid, FWD_ON);
    chk("t4_fwd_data", rs2_fwd_data, FWD_ON ? 32'h2 : 32'h0);
    nxt(); #1;
    chk("t4_wen", rd_wen, 1);
    chk("t4_wide", rd_wide, 1);
    chk("t4_addr", rd_addr, 6);
    chk("t4_lo", rd_wdata, 32'h1);
    chk("t4_hi", rd_wdata_hi, 32'h2);
    chk("t4_busy_out", rs2_busy, 1);
    nxt(); #1;
    chk("t4_busy_off", rs2_busy, 0);
    nxt(); s1_valid = 1; s1_rd_addr = 7; #1;
    chk("t4_odd_ready", s1_ready, 1);
    nxt(); s1_valid = 0; #1;
    chk("t4_err", err_wide_odd, 1);
    chk("t4_odd_occ", occupancy, 0);
    chk("t4_odd_wen", rd_wen, 0);
    nxt(); #1;
    chk("t4_err_pulse", err_wide_odd, 0);
    chk("t4_odd_wen2", rd_wen, 0);

    // 5: narrow x0 is dropped; wide x0 is kept
    nxt(); s0_valid = 1; s0_wide = 0; s0_rd_addr = 0; s0_wdata = 32'h77; rs3_addr = 0; #1;
    chk("t5_ready", s0_ready, 1);
    chk("t5_busy_x0", rs3_busy, 0);
    nxt(); s0_valid = 0; #1;
    chk("t5_occ", occupancy, 0);
    chk("t5_busy_x0b", rs3_busy, 0);
    nxt(); #1;
    chk("t5_wen", rd_wen, 0);
    s1_valid = 1; s1_wide = 1; s1_rd_addr = 0; s1_wdata = 32'h55; s1_wdata_hi = 32'h66; rs1_addr = 1;
    nxt(); s1_valid = 0; s1_wide = 0; #1;
    chk("t5_w0_occ", occupancy, 1);
    chk("t5_w0_busy1", rs1_busy, 1);
    nxt(); #1;
    chk("t5_w0_wen", rd_wen, 1);
    chk("t5_w0_addr", rd_addr, 0);
    chk("t5_w0_hi", rd_wdata_hi, 32'h66);
    nxt(); #1;
    chk("t5_w0_idle", rd_wen, 0);

    // 6: reset with three entries queued and a live write
    wb_hold = 1; rs1_addr = 21;
    for (int i = 0; i < 4; i++) begin
      nxt(); s0_valid = 1; s0_rd_addr = 5'(20 + i); s0_wdata = 32'h200 + i;
    end
    nxt(); s0_valid = 0; wb_hold = 0;
    nxt(); #1;
    chk("t6_pre_wen", rd_wen, 1);
    chk("t6_pre_occ", occupancy, 3);
    chk("t6_pre_busy", rs1_busy, 1);
    g_reset = 1; #1;
    chk("t6_rst_wen", rd_wen, 0);
    chk("t6_rst_addr", rd_addr, 0);
    chk("t6_rst_wdata", rd_wdata, 0);
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_busy", rs1_busy, 0);
    nxt(); g_reset = 0;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("t6_post_wen", rd_wen, 0);
      chk("t6_post_occ", occupancy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
